mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported memory instance (the common write/read interface: `wraddress`, `rdaddress`, `wren`, `data`, `q`, one-cycle read latency) between the CPU data port (port 0) and the audio DMA engine (port 1). Port 0 has priority. A per-cycle wait counter guarantees that port 1 is granted within a bounded number of cycles. The block returns read data to the requester that issued the read, tagged by a one-cycle pipeline register.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fixed-priority memory arbiter with bounded port-1 wait
//
// Shares one single-ported memory (one-cycle read latency) between the CPU data
// port (port 0, priority) and the audio DMA port (port 1). A saturating wait
// counter lets port 1 win contention once it has been denied MAX_WAIT cycles
// in a row. Read data is steered back to the issuing port by a one-cycle tag.
//
// Ports:
//   clock, aclr            clock, synchronous active-high reset
//   req/we/addr/wdata 0,1  requester inputs, held stable until gnt
//   gnt0, gnt1             combinational accept, at most one high per cycle
//   rvalid0/1, rdata0/1    read return, one cycle after the granted read
//   wraddress, rdaddress   memory addresses (both driven by the granted addr)
//   wren, data             memory write enable and write data
//   q                      memory read data, one cycle after rdaddress
module mem_arbiter #(
  parameter int width    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [15:0]      addr0,
  input  logic [15:0]      addr1,
  input  logic [width-1:0] wdata0,
  input  logic [width-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [width-1:0] rdata0,
  output logic [width-1:0] rdata1,
  output logic [15:0]      wraddress,
  output logic [15:0]      rdaddress,
  output logic             wren,
  output logic [width-1:0] data,
  input  logic [width-1:0] q
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;

  // Grant decision and memory drive
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    wren      = 1'b0;
    wraddress = '0;
    rdaddress = '0;
    data      = '0;
    if (!aclr) begin
      // Port 1 only beats a pending port 0 once it has waited long enough
      if (req1 && (!req0 || (wait_cnt_q >= MAX_WAIT_C))) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
    if (gnt0) begin
      wraddress = addr0;
      rdaddress = addr0;
      wren      = we0;
      data      = wdata0;
    end else if (gnt1) begin
      wraddress = addr1;
      rdaddress = addr1;
      wren      = we1;
      data      = wdata1;
    end
  end

  // Next-state for the wait counter and the read tag pipeline
  always_comb begin
    wait_cnt_d = 8'd0;
    if (req1 && !gnt1) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
    rd_pend_d = (gnt0 && !we0) || (gnt1 && !we1);
    rd_port_d = rd_port_q;
    if (rd_pend_d) begin
      rd_port_d = gnt1;
    end
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      wait_cnt_q <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_port_q  <= rd_port_d;
    end
  end

  // Masking with aclr drops a read whose return would land in the first reset
  // cycle, before the registers have been cleared by the reset edge.
  always_comb begin
    rvalid0 = rd_pend_q && !rd_port_q && !aclr;
    rvalid1 = rd_pend_q &&  rd_port_q && !aclr;
    rdata0  = rvalid0 ? q : '0;
    rdata1  = rvalid1 ? q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        aclr;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] wraddress, rdaddress;
  logic        wren;
  logic [15:0] data;
  logic [15:0] q;

  logic [15:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.width(16), .MAX_WAIT(4)) dut (
    .clock(clock), .aclr(aclr),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .wraddress(wraddress), .rdaddress(rdaddress), .wren(wren), .data(data),
    .q(q)
  );

  always #5 clock = ~clock;

  // Single-ported memory model, preloaded while reset is held
  always @(posedge clock) begin
    if (aclr) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h01] <= 16'hAAAA;
      mem[8'h02] <= 16'h5555;
    end else if (wren) begin
      mem[wraddress[7:0]] <= data;
    end
    q <= mem[rdaddress[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_g1;
    logic prev_g1;
    aclr = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    next_cycle();

    // Reset held two cycles with both requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_wren", wren, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rvalid1", rvalid1, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_wait_cnt", dut.wait_cnt_q, 0);
      next_cycle();
    end
    aclr = 1'b0;
    @(negedge clock);
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    next_cycle();

    // Single-port read on port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    @(negedge clock);
    check("rd1_gnt1", gnt1, 1);
    check("rd1_gnt0", gnt0, 0);
    check("rd1_rdaddress", rdaddress, 16'h0010);
    check("rd1_wren", wren, 0);
    next_cycle();
    req1 = 1'b0;
    @(negedge clock);
    check("rd1_rvalid1", rvalid1, 1);
    check("rd1_rdata1", rdata1, 16'hBEEF);
    check("rd1_rvalid0", rvalid0, 0);
    check("rd1_rdata0", rdata0, 0);
    next_cycle();

    // Port 0 write then read-back
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
    @(negedge clock);
    check("wr0_gnt0", gnt0, 1);
    check("wr0_wren", wren, 1);
    check("wr0_data", data, 16'h1234);
    check("wr0_wraddress", wraddress, 16'h0020);
    next_cycle();
    we0 = 1'b0;
    @(negedge clock);
    check("wr0_no_rvalid", rvalid0, 0);
    check("rb0_wren", wren, 0);
    next_cycle();
    req0 = 1'b0;
    @(negedge clock);
    check("rb0_rvalid0", rvalid0, 1);
    check("rb0_rdata0", rdata0, 16'h1234);
    next_cycle();

    // Starvation bound: continuous contention, port 1 every fifth cycle
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    prev_g1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_g1 = ((i % 5) == 4);
      @(negedge clock);
      check("starve_wait_cnt", dut.wait_cnt_q, i % 5);
      check("starve_gnt1", gnt1, exp_g1);
      check("starve_gnt0", gnt0, !exp_g1);
      if (i > 0) begin
        check("starve_rvalid1", rvalid1, prev_g1);
        check("starve_rvalid0", rvalid0, !prev_g1);
      end
      prev_g1 = exp_g1;
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    next_cycle();

    // Interleaved reads from alternating ports
    addr0 = 16'h0001; addr1 = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      req0 = ((i % 2) == 0);
      req1 = ((i % 2) == 1);
      @(negedge clock);
      check("ilv_gnt0", gnt0, (i % 2) == 0);
      check("ilv_gnt1", gnt1, (i % 2) == 1);
      check("ilv_both_rvalid", rvalid0 & rvalid1, 0);
      if (i > 0) begin
        if ((i % 2) == 1) begin
          check("ilv_rvalid0", rvalid0, 1);
          check("ilv_rdata0", rdata0, 16'hAAAA);
        end else begin
          check("ilv_rvalid1", rvalid1, 1);
          check("ilv_rdata1", rdata1, 16'h5555);
        end
      end
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check("ilv_last_rvalid1", rvalid1, 1);
    check("ilv_last_rdata1", rdata1, 16'h5555);
    next_cycle();

    // Write right after a read leaves the read return intact
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    next_cycle();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h7777;
    @(negedge clock);
    check("rw_gnt0", gnt0, 1);
    check("rw_wren", wren, 1);
    check("rw_rvalid1", rvalid1, 1);
    check("rw_rdata1", rdata1, 16'hBEEF);
    next_cycle();
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clock);
    check("rw_no_rvalid0", rvalid0, 0);
    next_cycle();

    // Reset arriving right after a granted read drops its return
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    @(negedge clock);
    check("mid_gnt1", gnt1, 1);
    next_cycle();
    req1 = 1'b0; aclr = 1'b1;
    @(negedge clock);
    check("mid_rvalid1_n1", rvalid1, 0);
    check("mid_rdata1_n1", rdata1, 0);
    next_cycle();
    aclr = 1'b0;
    @(negedge clock);
    check("mid_rvalid1_n2", rvalid1, 0);
    check("mid_wait_cnt", dut.wait_cnt_q, 0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
